// File: rtl/ser_video_fifo.sv
// Parallel-pixel to multi-lane serial video shifter with a DEPTH-entry input FIFO.
// Each pixel is sent as WIDTH bit periods of 2*DIV cycles followed by a 2*DIV-cycle latch pulse.
module ser_video_fifo #(
  parameter int CHANNELS        = 3,
  parameter int WIDTH           = 7,
  parameter int DEPTH           = 4,
  parameter int DIV             = 1,
  parameter int MSB_FIRST       = 1,
  parameter int REPEAT_ON_EMPTY = 0
) (
  input  logic                          CLK_SERVID,
  input  logic                          RESET,
  input  logic                          PIX_STB,
  input  logic [CHANNELS*WIDTH-1:0]     PIX_DATA,
  input  logic                          CLR_STAT,
  output logic [CHANNELS-1:0]           SER_DATA,
  output logic                          SER_CLK,
  output logic                          SER_LAT,
  output logic [$clog2(DEPTH):0]        LEVEL,
  output logic                          OVERFLOW,
  output logic                          UNDERRUN,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(2 * DIV) + 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam int PW = CHANNELS * WIDTH;

  localparam logic [CW-1:0] CNT_LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] CNT_HIGH = CW'(DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [PW-1:0]   last_pix;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;

  logic frame_last;
  logic pop;
  logic push_ok;
  logic overflow_set;
  logic underrun_set;

  // Lane values for bit period b of a pixel, honouring the configured bit order.
  function automatic logic [CHANNELS-1:0] lane_bits(input logic [PW-1:0] pix,
                                                    input logic [BW-1:0] b);
    logic [CHANNELS-1:0] r;
    logic [PW-1:0]       tmp;
    int                  sel;
    r   = '0;
    sel = (MSB_FIRST != 0) ? (WIDTH - 1 - int'(b)) : int'(b);
    for (int c = 0; c < CHANNELS; c++) begin
      tmp = pix >> (c * WIDTH + sel);
      r   = r | (CHANNELS'(tmp[0]) << c);
    end
    return r;
  endfunction

  assign frame_last   = (state == LATCH) && (cnt == CNT_LAST);
  assign pop          = (LEVEL != '0) && ((state == IDLE) || frame_last);
  assign push_ok      = PIX_STB && ((LEVEL != LVL_FULL) || pop);
  assign overflow_set = PIX_STB && !push_ok;
  assign underrun_set = frame_last && (LEVEL == '0) && (REPEAT_ON_EMPTY != 0);
  assign dbg_state    = state;

  // Storage is not reset; only the pointers define valid contents.
  always_ff @(posedge CLK_SERVID) begin
    if (push_ok) mem[wr_ptr] <= PIX_DATA;
  end

  always_ff @(posedge CLK_SERVID) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      LEVEL    <= '0;
      OVERFLOW <= 1'b0;
      UNDERRUN <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   LEVEL <= LEVEL + 1'b1;
        2'b01:   LEVEL <= LEVEL - 1'b1;
        default: LEVEL <= LEVEL;
      endcase
      if (overflow_set)  OVERFLOW <= 1'b1;
      else if (CLR_STAT) OVERFLOW <= 1'b0;
      if (underrun_set)  UNDERRUN <= 1'b1;
      else if (CLR_STAT) UNDERRUN <= 1'b0;
    end
  end

  // Outputs are loaded with the values for the cycle being entered.
  always_ff @(posedge CLK_SERVID) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      last_pix <= '0;
      SER_DATA <= '0;
      SER_CLK  <= 1'b0;
      SER_LAT  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          SER_CLK <= 1'b0;
          SER_LAT <= 1'b0;
          if (pop) begin
            last_pix <= mem[rd_ptr];
            SER_DATA <= lane_bits(mem[rd_ptr], '0);
            bit_idx  <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end else begin
            SER_DATA <= '0;
          end
        end
        SHIFT: begin
          if (cnt != CNT_LAST) begin
            cnt     <= cnt + 1'b1;
            SER_CLK <= ((cnt + 1'b1) >= CNT_HIGH);
          end else begin
            cnt     <= '0;
            SER_CLK <= 1'b0;
            if (bit_idx == BIT_LAST) begin
              SER_LAT <= 1'b1;
              state   <= LATCH;
            end else begin
              bit_idx  <= bit_idx + 1'b1;
              SER_DATA <= lane_bits(last_pix, bit_idx + 1'b1);
            end
          end
        end
        LATCH: begin
          if (cnt != CNT_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt     <= '0;
            bit_idx <= '0;
            SER_LAT <= 1'b0;
            if (pop) begin
              last_pix <= mem[rd_ptr];
              SER_DATA <= lane_bits(mem[rd_ptr], '0);
              state    <= SHIFT;
            end else if (REPEAT_ON_EMPTY != 0) begin
              SER_DATA <= lane_bits(last_pix, '0);
              state    <= SHIFT;
            end else begin
              SER_DATA <= '0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_video_fifo.sv
// Bench for ser_video_fifo: a default instance against a queue-based timing model,
// plus directed frames on a repeat-on-empty instance and a slow LSB-first instance.
module tb_ser_video_fifo;

  localparam int CH  = 3;
  localparam int W   = 7;
  localparam int D   = 4;
  localparam int DA  = 1;
  localparam int FR  = 2 * DA * (W + 1);
  localparam int PWA = CH * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Default instance
  logic             rst_a = 1'b1, stb_a = 1'b0, clr_a = 1'b0;
  logic [PWA-1:0]   data_a = '0;
  logic [CH-1:0]    ser_data_a;
  logic             ser_clk_a, ser_lat_a, ovf_a, ur_a;
  logic [2:0]       level_a;
  logic [1:0]       st_a;

  // Repeat-on-empty instance
  logic             rst_r = 1'b1, stb_r = 1'b0, clr_r = 1'b0;
  logic [PWA-1:0]   data_r = '0;
  logic [CH-1:0]    ser_data_r;
  logic             ser_clk_r, ser_lat_r, ovf_r, ur_r;
  logic [2:0]       level_r;
  logic [1:0]       st_r;

  // DIV=3, LSB-first, 4-bit instance
  logic             rst_d = 1'b1, stb_d = 1'b0, clr_d = 1'b0;
  logic [11:0]      data_d = '0;
  logic [CH-1:0]    ser_data_d;
  logic             ser_clk_d, ser_lat_d, ovf_d, ur_d;
  logic [2:0]       level_d;
  logic [1:0]       st_d;

  ser_video_fifo u_a (
    .CLK_SERVID(clk), .RESET(rst_a), .PIX_STB(stb_a), .PIX_DATA(data_a), .CLR_STAT(clr_a),
    .SER_DATA(ser_data_a), .SER_CLK(ser_clk_a), .SER_LAT(ser_lat_a), .LEVEL(level_a),
    .OVERFLOW(ovf_a), .UNDERRUN(ur_a), .dbg_state(st_a)
  );

  ser_video_fifo #(.REPEAT_ON_EMPTY(1)) u_r (
    .CLK_SERVID(clk), .RESET(rst_r), .PIX_STB(stb_r), .PIX_DATA(data_r), .CLR_STAT(clr_r),
    .SER_DATA(ser_data_r), .SER_CLK(ser_clk_r), .SER_LAT(ser_lat_r), .LEVEL(level_r),
    .OVERFLOW(ovf_r), .UNDERRUN(ur_r), .dbg_state(st_r)
  );

  ser_video_fifo #(.WIDTH(4), .DIV(3), .MSB_FIRST(0)) u_d (
    .CLK_SERVID(clk), .RESET(rst_d), .PIX_STB(stb_d), .PIX_DATA(data_d), .CLR_STAT(clr_d),
    .SER_DATA(ser_data_d), .SER_CLK(ser_clk_d), .SER_LAT(ser_lat_d), .LEVEL(level_d),
    .OVERFLOW(ovf_d), .UNDERRUN(ur_d), .dbg_state(st_d)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [PWA-1:0] d);
    stb_a  = 1'b1;
    data_a = d;
    tick();
    stb_a  = 1'b0;
  endtask

  // Reference model for u_a: pixel queue plus frame start times; outputs derived by arithmetic.
  logic [PWA-1:0] exp_q[$];
  logic [PWA-1:0] cur_pix = '0;
  logic [PWA-1:0] m_tmp;
  bit             m_active = 1'b0;
  bit             m_ovf = 1'b0, m_ur = 1'b0;
  bit             m_last, m_pop, m_acc;
  int             m_fs = 0, m_p, m_bi, m_sb;
  logic [CH-1:0]  e_dat;
  logic           e_clk, e_lat;

  always @(negedge clk) begin
    if (chk_en) begin
      e_dat = '0;
      e_clk = 1'b0;
      e_lat = 1'b0;
      if (m_active) begin
        m_p  = cyc - m_fs;
        m_bi = m_p / (2 * DA);
        if (m_bi < W) begin
          e_clk = ((m_p % (2 * DA)) >= DA);
          m_sb  = m_bi;
        end else begin
          e_lat = 1'b1;
          m_sb  = W - 1;
        end
        for (int ch = 0; ch < CH; ch++) begin
          m_tmp = cur_pix >> (ch * W + (W - 1 - m_sb));
          e_dat = e_dat | (CH'(m_tmp[0]) << ch);
        end
      end
      chk("a_ser_data", ser_data_a, e_dat);
      chk("a_ser_clk", ser_clk_a, e_clk);
      chk("a_ser_lat", ser_lat_a, e_lat);
      chk("a_level", level_a, exp_q.size());
      chk("a_overflow", ovf_a, m_ovf);
      chk("a_underrun", ur_a, m_ur);
    end
    if (rst_a) begin
      exp_q.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_ur     = 1'b0;
    end else begin
      m_last = m_active && (cyc == m_fs + FR - 1);
      m_pop  = (!m_active || m_last) && (exp_q.size() > 0);
      m_acc  = stb_a && ((exp_q.size() < D) || m_pop);
      if (m_pop) begin
        cur_pix  = exp_q.pop_front();
        m_active = 1'b1;
        m_fs     = cyc + 1;
      end else if (m_last) begin
        m_active = 1'b0;
      end
      if (m_acc) exp_q.push_back(data_a);
      if (stb_a && !m_acc) m_ovf = 1'b1;
      else if (clr_a)      m_ovf = 1'b0;
      if (clr_a) m_ur = 1'b0;
    end
  end

  // Checks one full frame of u_r (use_d=0) or u_d (use_d=1), starting after skip cycles.
  task automatic check_frame(input bit use_d, input logic [20:0] pix, input int w, input int dv,
                             input bit msb, input int skip, input string tag);
    int            bi, sb, ord;
    logic [2:0]    edat, odat;
    logic          eclk, elat, oclk, olat;
    logic [20:0]   tmp;
    for (int i = 0; i < skip; i++) @(negedge clk);
    for (int p = 0; p < 2 * dv * (w + 1); p++) begin
      @(negedge clk);
      bi = p / (2 * dv);
      if (bi < w) begin
        eclk = ((p % (2 * dv)) >= dv);
        elat = 1'b0;
        sb   = bi;
      end else begin
        eclk = 1'b0;
        elat = 1'b1;
        sb   = w - 1;
      end
      ord  = msb ? (w - 1 - sb) : sb;
      edat = '0;
      for (int ch = 0; ch < 3; ch++) begin
        tmp  = pix >> (ch * w + ord);
        edat = edat | (3'(tmp[0]) << ch);
      end
      odat = use_d ? ser_data_d : ser_data_r;
      oclk = use_d ? ser_clk_d  : ser_clk_r;
      olat = use_d ? ser_lat_d  : ser_lat_r;
      chk({tag, "_data"}, odat, edat);
      chk({tag, "_clk"},  oclk, eclk);
      chk({tag, "_lat"},  olat, elat);
    end
  endtask

  initial begin
    int budget;

    // Reset all instances
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("r_reset_data", ser_data_r, 0);
    chk("r_reset_level", level_r, 0);
    chk("r_reset_flags", {ovf_r, ur_r, ser_clk_r, ser_lat_r}, 0);
    chk("d_reset_data", ser_data_d, 0);
    chk("d_reset_level", level_d, 0);
    chk("d_reset_flags", {ovf_d, ur_d, ser_clk_d, ser_lat_d}, 0);
    tick();
    rst_a = 1'b0;
    rst_r = 1'b0;
    rst_d = 1'b0;
    tick();

    // Single pixel {ch2=55, ch1=00, ch0=7F}
    push_a({7'h55, 7'h00, 7'h7F});
    repeat (20) tick();

    // Five back-to-back pushes fill the FIFO, the sixth is dropped
    for (int i = 0; i < 6; i++) push_a(PWA'($urandom));
    @(negedge clk);
    chk("a_ovf_after_sixth", ovf_a, 1);
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;

    // Push in the final latch cycle while full: accepted
    budget = 0;
    while (!(m_active && (cyc == m_fs + FR - 1)) && budget < 100) begin
      tick();
      budget++;
    end
    chk("a_frame_end_reached", (budget < 100), 1);
    push_a(PWA'($urandom));
    @(negedge clk);
    chk("a_coinc_level", level_a, 4);
    chk("a_coinc_ovf", ovf_a, 0);
    repeat (120) tick();

    // Reset mid-SHIFT with two pixels queued
    push_a(PWA'($urandom));
    push_a(PWA'($urandom));
    push_a(PWA'($urandom));
    @(negedge clk);
    chk("a_level_before_reset", level_a, 2);
    tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    @(negedge clk);
    chk("a_post_reset_out", {ser_data_a, ser_clk_a, ser_lat_a}, 0);
    chk("a_post_reset_level", level_a, 0);
    tick();
    push_a({7'h2A, 7'h13, 7'h66});
    repeat (20) tick();

    // Repeat-on-empty: frame resent, underrun sticky, cleared and set again
    stb_r  = 1'b1;
    data_r = {7'h01, 7'h01, 7'h01};
    tick();
    stb_r  = 1'b0;
    check_frame(1'b0, {7'h01, 7'h01, 7'h01}, 7, 1, 1'b1, 1, "r_frame1");
    chk("r_underrun_first", ur_r, 0);
    check_frame(1'b0, {7'h01, 7'h01, 7'h01}, 7, 1, 1'b1, 0, "r_frame2");
    chk("r_underrun_set", ur_r, 1);
    chk("r_level_empty", level_r, 0);
    tick();
    clr_r = 1'b1;
    tick();
    clr_r = 1'b0;
    @(negedge clk);
    chk("r_underrun_cleared", ur_r, 0);
    repeat (14) @(negedge clk);
    chk("r_underrun_still_clear", ur_r, 0);
    @(negedge clk);
    chk("r_underrun_reset_again", ur_r, 1);
    tick();
    rst_r = 1'b1;
    tick();
    rst_r = 1'b0;

    // DIV=3, LSB first, 4-bit pixel 0001 on all lanes
    tick();
    stb_d  = 1'b1;
    data_d = 12'h111;
    tick();
    stb_d  = 1'b0;
    check_frame(1'b1, 21'(12'h111), 4, 3, 1'b0, 1, "d_frame");
    @(negedge clk);
    chk("d_idle_out", {ser_data_d, ser_clk_d, ser_lat_d}, 0);
    chk("d_idle_level", level_d, 0);

    // Random traffic on the default instance
    tick();
    for (int i = 0; i < 900; i++) begin
      stb_a  = ($urandom_range(0, 99) < 35);
      data_a = PWA'($urandom);
      clr_a  = ($urandom_range(0, 39) == 0);
      tick();
    end
    stb_a = 1'b0;
    clr_a = 1'b0;
    repeat (150) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ser_video_fifo.md
Name: ser_video_fifo

Overview:
- Parametrised successor to the fixed RGB video serialiser.
- Accepts parallel pixels (CHANNELS x WIDTH bits) on a strobe and buffers them in a DEPTH-entry FIFO.
- Shifts each pixel out on CHANNELS serial lines with a generated bit clock and a latch pulse per pixel.
- Sits between videout and the external shift-register/DAC pins; adds bit order, clock-divide and underrun modes plus status flags.

Parameters:
- CHANNELS, 3: number of serial lanes (R, G, B).
- WIDTH, 7: bits per channel per pixel.
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- DIV, 1: SER_CLK half-period in CLK_SERVID cycles; >= 1.
- MSB_FIRST, 1: 1 = bit WIDTH-1 shifted first; 0 = bit 0 first.
- REPEAT_ON_EMPTY, 0: 1 = resend last pixel when FIFO empty at frame end; 0 = go idle.

Ports:
- CLK_SERVID  in  1  single clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- PIX_STB  in  1  one-cycle push strobe.
- PIX_DATA  in  CHANNELS*WIDTH  pixel. Channel c occupies [c*WIDTH +: WIDTH]; channel 0 drives SER_DATA[0].
- CLR_STAT  in  1  clears the sticky flags.
- SER_DATA  out  CHANNELS  serial lane data.
- SER_CLK  out  1  bit clock; the receiver samples on its rising edge.
- SER_LAT  out  1  latch pulse after the last bit of each pixel.
- LEVEL  out  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky: a push was dropped.
- UNDERRUN  out  1  sticky: a pixel was repeated.

Behaviour:
- Reset (any cycle, including mid-frame):
  - SER_DATA=0, SER_CLK=0, SER_LAT=0.
  - LEVEL=0, flags=0, state=IDLE, last-pixel register=0.
  - Pointers cleared; FIFO contents need not be cleared.
- FIFO:
  - Registered and circular; pointers wrap modulo DEPTH.
  - No fall-through: a pushed word is first visible to the shifter the next cycle.
  - Push accepted when LEVEL<DEPTH, or when LEVEL==DEPTH and a pop occurs in the same cycle.
  - Push while full with no pop: data dropped, OVERFLOW=1.
  - Simultaneous push and pop leaves LEVEL unchanged.
- State machine:
  - IDLE: SER_CLK=0, SER_LAT=0, SER_DATA=0.
    - If LEVEL>0: pop into the shift register and last-pixel register, bit=0, go to SHIFT.
  - SHIFT: each bit lasts 2*DIV cycles.
    - SER_CLK=0 for the first DIV cycles, 1 for the next DIV cycles.
    - SER_DATA[c] holds the current bit of channel c for all 2*DIV cycles.
    - After bit WIDTH-1, go to LATCH.
  - LATCH: SER_CLK=0, SER_LAT=1 for 2*DIV cycles, SER_DATA holds the final bit. At the last LATCH cycle:
    - LEVEL>0: pop, go to SHIFT (back-to-back, no idle cycle).
    - LEVEL==0 and REPEAT_ON_EMPTY=1: reload last pixel, UNDERRUN=1, go to SHIFT.
    - Otherwise go to IDLE.
- Frame length = 2*DIV*(WIDTH+1) cycles (16 at defaults).
- Latency: PIX_STB in cycle t with FIFO empty and state IDLE gives pop in cycle t+1 and first bit on SER_DATA in cycle t+2.
- Bit order:
  - MSB_FIRST=1 sends bit WIDTH-1 down to bit 0.
  - MSB_FIRST=0 sends bit 0 up to bit WIDTH-1.
- Flags:
  - CLR_STAT clears both flags the next cycle.
  - If a new set event occurs in the same cycle as CLR_STAT, the set wins.
- All outputs are registered.

Test Plan:
- Reset, then push PIX_DATA = {ch2=7'h55, ch1=7'h00, ch0=7'h7F}, defaults:
  - First bit at t+2.
  - SER_DATA[0]=1 for 7 bits; SER_DATA[2] sequence 1,0,1,0,1,0,1.
  - 7 SER_CLK rising edges, then SER_LAT high for 2 cycles; back to IDLE at t+18.
- Push 5 pixels on consecutive cycles with DEPTH=4 and state IDLE:
  - Pixel 0 pops at t+1, so pixels 1..4 fill the FIFO and all are accepted; LEVEL reaches 4.
  - A 6th push at t+5 is dropped and OVERFLOW=1.
  - All 5 frames stream back-to-back with no idle cycles between SER_LAT and the next bit.
- REPEAT_ON_EMPTY=1, single push of 7'h01 on all channels:
  - Second frame repeats the same bits and UNDERRUN=1.
  - CLR_STAT clears UNDERRUN; it is set again at the next frame end.
- DIV=3, MSB_FIRST=0, WIDTH=4, pixel 4'b0001:
  - Each bit lasts 6 cycles, SER_CLK low 3 / high 3.
  - Lane data reads 1,0,0,0; SER_LAT lasts 6 cycles.
- RESET asserted mid-SHIFT with LEVEL=2:
  - Next cycle all outputs are 0, LEVEL=0, state IDLE.
  - A subsequent push produces a clean frame.
- With LEVEL=4, push during the final LATCH cycle of a frame (pop coincident):
  - Push is accepted, LEVEL stays 4, OVERFLOW stays 0.
